// File: rtl/lam_controller.sv
// Load/store sequencer: one memory op at a time over a req/ack bus, load data aligned and extended to writeback.
// Latency: store 1+ cycles busy, load 2+ cycles busy; illegal/misaligned ops rejected in one cycle with no bus activity.
// Backpressure: busy holds the core while an access is in flight; lam_new is ignored unless IDLE.
module lam_controller #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lam_new,
    input  logic [8:0]  lam_control,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_sel,
    output logic [31:0] wb_data,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WB     = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        lat_store;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic [7:0]  tmo_cnt;

    logic        op_store;
    logic [2:0]  op_funct3;
    logic        op_legal;
    logic        op_aligned;
    logic [3:0]  op_be;
    logic [31:0] op_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    logic        accept;
    logic        reject;
    logic        ack_hit;
    logic        timeout_hit;

    assign op_store  = lam_control[8];
    assign op_funct3 = lam_control[7:5];

    // Decode and pre-compute bus lanes of the incoming op so ACCESS only replays registers
    always_comb begin
        op_legal   = 1'b0;
        op_aligned = 1'b0;
        op_be      = 4'b1111;
        op_wdata   = store_data;
        case (op_funct3)
            3'b000, 3'b001, 3'b010: op_legal = 1'b1;
            3'b100, 3'b101:         op_legal = !op_store;
            default:                op_legal = 1'b0;
        endcase
        case (op_funct3[1:0])
            2'b00: begin
                op_aligned = 1'b1;
                op_be      = 4'b0001 << addr[1:0];
                op_wdata   = {4{store_data[7:0]}};
            end
            2'b01: begin
                op_aligned = !addr[0];
                op_be      = addr[1] ? 4'b1100 : 4'b0011;
                op_wdata   = {2{store_data[15:0]}};
            end
            default: begin
                op_aligned = (addr[1:0] == 2'b00);
                op_be      = 4'b1111;
                op_wdata   = store_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (lat_off)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        reject      = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (lam_new) begin
                    if (op_legal && op_aligned) begin
                        accept    = 1'b1;
                        state_nxt = ACCESS;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // An ack on the final allowed cycle still completes the access
                if (mem_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = lat_store ? IDLE : WB;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WB: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_store    <= 1'b0;
            lat_funct3   <= 3'd0;
            lat_off      <= 2'd0;
            tmo_cnt      <= 8'd0;
            mem_addr     <= 32'd0;
            mem_be       <= 4'd0;
            mem_wdata    <= 32'd0;
            wb_sel       <= 5'd0;
            wb_data      <= 32'd0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= reject;
            bus_err      <= timeout_hit;
            if (accept) begin
                lat_store  <= op_store;
                lat_funct3 <= op_funct3;
                lat_off    <= addr[1:0];
                tmo_cnt    <= 8'd0;
                mem_addr   <= {addr[31:2], 2'b00};
                mem_be     <= op_be;
                mem_wdata  <= op_wdata;
                wb_sel     <= lam_control[4:0];
            end else if (state == ACCESS && !mem_ack) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
            if (ack_hit && !lat_store) begin
                wb_data <= ld_ext;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign mem_req = (state == ACCESS);
    assign mem_we  = mem_req && lat_store;
    assign wb_en   = (state == WB) && (wb_sel != 5'd0);

endmodule
